seq_mult_8bit_ctrl: RTL and testbench

//  Sequencer for one shared rippleAdder_8bit instance: computes an unsigned 8x8->16 product
//  by iterative shift-and-add, one adder pass per clock. Sits beside the adder in the datapath
//  and owns its A/B operand muxing. Adder cin is tied to 1'b0.

---
 rtl/seq_mult_8bit_ctrl_if.sv | 12 +
 rtl/seq_mult_8bit_ctrl.sv | 63 ++++++
 tb/tb_seq_mult_8bit_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seq_mult_8bit_ctrl_if.sv
// seq_mult_8bit_ctrl_if: start/busy/done request interface for the sequential multiplier
// master is the requester, slave is the multiplier controller.
interface seq_mult_8bit_ctrl_if;
    logic        start;
    logic [7:0]  mcand;
    logic [7:0]  mplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    modport master (output start, mcand, mplier, input busy, done, product);
    modport slave (input start, mcand, mplier, output busy, done, product);
endinterface

// File: rtl/seq_mult_8bit_ctrl.sv
// seq_mult_8bit_ctrl: unsigned 8x8->16 shift-and-add multiplier, one 8-bit adder pass per clock.
// Optional macro SEQ_MULT_ZERO_BYPASS_EN finishes immediately when either operand is zero.
module seq_mult_8bit_ctrl #(
    parameter int WIDTH = 8,
    parameter bit DONE_PULSE = 1'b1
) (
    input logic clk,
    input logic rst,
    seq_mult_8bit_ctrl_if.slave s
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] m, a, q;
    logic [3:0] cnt;
    logic [WIDTH:0] sum;
    logic zero_op;
    // The adder carry lands in the top bit of A after the shift, so no separate C register is kept.
    always_comb sum = {1'b0, a} + {1'b0, q[0] ? m : '0};
`ifdef SEQ_MULT_ZERO_BYPASS_EN
    always_comb zero_op = (s.mcand == '0) || (s.mplier == '0);
`else
    always_comb zero_op = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s.busy <= 1'b0;
            s.done <= 1'b0;
            s.product <= '0;
            m <= '0;
            a <= '0;
            q <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (s.start) begin
                    m <= s.mcand;
                    q <= s.mplier;
                    a <= '0;
                    cnt <= '0;
                    state <= zero_op ? DONE : BUSY;
                    s.busy <= !zero_op;
                    s.done <= zero_op;
                    if (zero_op) s.product <= '0;
                end
                BUSY: begin
                    {a, q} <= {sum, q[WIDTH-1:1]};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(WIDTH - 1)) begin
                        state <= DONE;
                        s.busy <= 1'b0;
                        s.done <= 1'b1;
                        s.product <= {sum, q[WIDTH-1:1]};
                    end
                end
                default: begin
                    state <= IDLE;
                    s.done <= !DONE_PULSE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_8bit_ctrl.sv
// tb_seq_mult_8bit_ctrl: directed vectors with a product/busy-length scoreboard checked by a monitor.
module tb_seq_mult_8bit_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [15:0] exp_p[$];
    int exp_b[$];
`ifdef SEQ_MULT_ZERO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    seq_mult_8bit_ctrl_if bus ();
    seq_mult_8bit_ctrl dut (.clk(clk), .rst(rst), .s(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: measures busy run length and pops the scoreboard on every done.
    int busy_run = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
            prev_done = 1'b0;
        end else begin
            if (bus.busy && bus.done) check("busy_and_done", 1, 0);
            if (bus.busy) busy_run++;
            if (bus.done) begin
                if (exp_p.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("product", bus.product, exp_p.pop_front());
                    check("busy_cycles", busy_run, exp_b.pop_front());
                    check("done_pulse", prev_done, 0);
                end
                busy_run = 0;
            end
            prev_done = bus.done;
        end
    end

    task automatic push_exp(input logic [15:0] p, input bit zero);
        exp_p.push_back(p);
        exp_b.push_back((BYP && zero) ? 0 : 8);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                          input bit zero, input bit inject);
        bus.start = 1'b1;
        bus.mcand = a;
        bus.mplier = b;
        push_exp(p, zero);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mcand = ~a;
        bus.mplier = b ^ 8'h5a;
        if (inject) begin
            repeat (2) @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.mcand = 8'd3;
            bus.mplier = 8'd3;
            repeat (3) @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_done();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.mcand = '0;
        bus.mplier = '0;
        #1;
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(8'd5, 8'd9, 16'h002D, 1'b0, 1'b0);
        run_op(8'd111, 8'd41, 16'h11C7, 1'b0, 1'b0);
        run_op(8'd15, 8'd9, 16'h0087, 1'b0, 1'b0);
        run_op(8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0);
        run_op(8'd100, 8'd200, 16'h4E20, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("product_hold", bus.product, 16'h4E20);
        // start held high: second operation is captured on the first IDLE edge after done
        bus.start = 1'b1;
        bus.mcand = 8'd7;
        bus.mplier = 8'd6;
        push_exp(16'h002A, 1'b0);
        @(posedge clk);
        #1;
        bus.mcand = 8'd10;
        bus.mplier = 8'd10;
        push_exp(16'h0064, 1'b0);
        wait_done();
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.mcand = 8'd99;
        bus.mplier = 8'd77;
        wait_done();
        @(posedge clk);
        #1;
        // async reset mid-operation discards the result
        bus.start = 1'b1;
        bus.mcand = 8'd200;
        bus.mplier = 8'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        check("async_rst_product", bus.product, 0);
        #14 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(8'd2, 8'd3, 16'h0006, 1'b0, 1'b0);
        run_op(8'd0, 8'd200, 16'h0000, 1'b1, 1'b0);
        run_op(8'd200, 8'd0, 16'h0000, 1'b1, 1'b0);
        run_op(8'd1, 8'd1, 16'h0001, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_p.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
